// File: rtl/pong_motion_ctrl_if.sv
// pong_motion_ctrl_if
// Groups the frame-update handshake and object-coordinate bus of the pong
// motion controller.
//   refr_tick, game_en, btn_up, btn_dn : controls driven by the master (sync/input side)
//   bar_y_t, ball_x_l, ball_y_t         : registered object coordinates (to rgb generator)
//   busy, hit, miss, hit_cnt            : sequence status and game events
interface pong_motion_ctrl_if;
  logic       refr_tick;
  logic       game_en;
  logic       btn_up;
  logic       btn_dn;
  logic [9:0] bar_y_t;
  logic [9:0] ball_x_l;
  logic [9:0] ball_y_t;
  logic       busy;
  logic       hit;
  logic       miss;
  logic [7:0] hit_cnt;

  modport master (
    output refr_tick, game_en, btn_up, btn_dn,
    input  bar_y_t, ball_x_l, ball_y_t, busy, hit, miss, hit_cnt
  );

  modport slave (
    input  refr_tick, game_en, btn_up, btn_dn,
    output bar_y_t, ball_x_l, ball_y_t, busy, hit, miss, hit_cnt
  );
endinterface

// File: rtl/pong_motion_ctrl.sv
// pong_motion_ctrl
// Once per video frame (refr_tick at start of vertical blanking) steps the
// bar from the buttons, moves the ball, and resolves wall / bar / screen-edge
// collisions. All coordinates are registered, so they only change in blanking.
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bus  : pong_motion_ctrl_if.slave (controls in, coordinates and events out)
//
// state | meaning
// IDLE  | waiting for refr_tick with game_en high
// BAR   | bar step from buttons
// MOVE  | ball step with wall-side and top/bottom clamps
// COLL  | direction updates, hit / miss events, respawn
module pong_motion_ctrl #(
  parameter int unsigned BAR_V     = 4,
  parameter int unsigned BALL_V    = 2,
  parameter int unsigned MAX_Y     = 480,
  parameter int unsigned MAX_X     = 640,
  parameter int unsigned WALL_XR   = 35,
  parameter int unsigned BAR_XL    = 600,
  parameter int unsigned BAR_XR    = 603,
  parameter int unsigned BAR_H     = 72,
  parameter int unsigned BALL_SIZE = 8
) (
  input  logic              clk,
  input  logic              rst,
  pong_motion_ctrl_if.slave bus
);

  // All position arithmetic is done 11 bits wide so no compare can wrap.
  localparam logic [10:0] BAR_V_W   = 11'(BAR_V);
  localparam logic [10:0] BALL_V_W  = 11'(BALL_V);
  localparam logic [10:0] MAX_Y_W   = 11'(MAX_Y);
  localparam logic [10:0] MAX_X_W   = 11'(MAX_X);
  localparam logic [10:0] BALL_XMIN = 11'(WALL_XR + 1);
  localparam logic [10:0] BALL_YMAX = 11'(MAX_Y - BALL_SIZE);
  localparam logic [10:0] BAR_XL_W  = 11'(BAR_XL);
  localparam logic [10:0] BAR_XR_W  = 11'(BAR_XR);
  localparam logic [10:0] BAR_H_W   = 11'(BAR_H);
  localparam logic [10:0] BALL_S_W  = 11'(BALL_SIZE);

  localparam logic [9:0] BAR_Y_RST  = 10'd204;
  localparam logic [9:0] BALL_X_RST = 10'd580;
  localparam logic [9:0] BALL_Y_RST = 10'd238;

  typedef enum logic [1:0] {S_IDLE, S_BAR, S_MOVE, S_COLL} state_t;

  state_t     state_q;
  logic [9:0] bar_q, ball_x_q, ball_y_q;
  logic       x_dir_q, y_dir_q;
  logic       busy_q, hit_q, miss_q;
  logic [7:0] hit_cnt_q;

  logic [9:0]  bar_d, ball_x_d, ball_y_d;
  logic        x_dir_d, y_dir_d;
  logic        bar_hit, ball_miss;
  logic [10:0] bar_w, bx_w, by_w, r_edge, b_edge;

  assign bar_w  = {1'b0, bar_q};
  assign bx_w   = {1'b0, ball_x_q};
  assign by_w   = {1'b0, ball_y_q};
  assign r_edge = bx_w + BALL_S_W - 11'd1;
  assign b_edge = by_w + BALL_S_W - 11'd1;

  always_comb begin
    bar_d = bar_q;
    if (bus.btn_up && !bus.btn_dn)
      bar_d = (bar_w >= BAR_V_W) ? 10'(bar_w - BAR_V_W) : 10'd0;
    else if (bus.btn_dn && !bus.btn_up)
      bar_d = (bar_w + BAR_H_W + BAR_V_W <= MAX_Y_W) ? 10'(bar_w + BAR_V_W)
                                                      : 10'(MAX_Y_W - BAR_H_W);

    // Rightward motion is unclamped; the miss check catches the right edge.
    if (x_dir_q)
      ball_x_d = 10'(bx_w + BALL_V_W);
    else
      ball_x_d = (bx_w >= BALL_XMIN + BALL_V_W) ? 10'(bx_w - BALL_V_W) : 10'(BALL_XMIN);

    if (y_dir_q)
      ball_y_d = (by_w + BALL_V_W <= BALL_YMAX) ? 10'(by_w + BALL_V_W) : 10'(BALL_YMAX);
    else
      ball_y_d = (by_w >= BALL_V_W) ? 10'(by_w - BALL_V_W) : 10'd0;

    bar_hit = x_dir_q && (r_edge >= BAR_XL_W) && (r_edge <= BAR_XR_W) &&
              (b_edge >= bar_w) && (by_w <= bar_w + BAR_H_W - 11'd1);
    ball_miss = (bx_w >= MAX_X_W - BALL_S_W) && !bar_hit;

    // Later assignments win: bar hit over wall, respawn over everything.
    x_dir_d = x_dir_q;
    y_dir_d = y_dir_q;
    if (by_w == 11'd0)      y_dir_d = 1'b1;
    if (by_w == BALL_YMAX)  y_dir_d = 1'b0;
    if (bx_w == BALL_XMIN)  x_dir_d = 1'b1;
    if (bar_hit)            x_dir_d = 1'b0;
    if (ball_miss) begin
      x_dir_d = 1'b0;
      y_dir_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      bar_q     <= BAR_Y_RST;
      ball_x_q  <= BALL_X_RST;
      ball_y_q  <= BALL_Y_RST;
      x_dir_q   <= 1'b0;
      y_dir_q   <= 1'b1;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      hit_cnt_q <= 8'd0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.refr_tick && bus.game_en) begin
            state_q <= S_BAR;
            busy_q  <= 1'b1;
          end
        end
        S_BAR: begin
          bar_q   <= bar_d;
          state_q <= S_MOVE;
        end
        S_MOVE: begin
          ball_x_q <= ball_x_d;
          ball_y_q <= ball_y_d;
          state_q  <= S_COLL;
        end
        S_COLL: begin
          x_dir_q <= x_dir_d;
          y_dir_q <= y_dir_d;
          hit_q   <= bar_hit;
          miss_q  <= ball_miss;
          if (bar_hit && hit_cnt_q != 8'hFF)
            hit_cnt_q <= hit_cnt_q + 8'd1;
          if (ball_miss) begin
            ball_x_q <= BALL_X_RST;
            ball_y_q <= BALL_Y_RST;
          end
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bar_y_t  = bar_q;
  assign bus.ball_x_l = ball_x_q;
  assign bus.ball_y_t = ball_y_q;
  assign bus.busy     = busy_q;
  assign bus.hit      = hit_q;
  assign bus.miss     = miss_q;
  assign bus.hit_cnt  = hit_cnt_q;

endmodule
